// File: rtl/array_pkg.sv
// Shared defaults and FSM state type for the systolic-array sequencer.
package array_pkg;
    localparam int N_DEF      = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        OUT
    } seq_state_t;
endpackage

// File: rtl/array_tile_buf.sv
// N x N tile store: one row-wide write port and an independent (row, column) read per lane.
module array_tile_buf
    import array_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANE_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [LANE_W-1:0]   wr_row,
    input  logic [N*DATA_W-1:0] wr_data,
    input  logic [N*LANE_W-1:0] rd_row,
    input  logic [N*LANE_W-1:0] rd_col,
    output logic [N*DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [N][N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (we) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_row][c] <= wr_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            rd_data[i*DATA_W +: DATA_W] = mem[rd_row[i*LANE_W +: LANE_W]][rd_col[i*LANE_W +: LANE_W]];
        end
    end
endmodule

// File: rtl/array_seq.sv
// Sequencer for an N x N systolic array: load, skewed feed, drain and result handshake.
// Optional cycle counter output perf_cycles is built when ARRAY_SEQ_PERF_EN is defined.
module array_seq
    import array_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANE_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic                ld_sel,
    input  logic [LANE_W-1:0]   ld_lane,
    input  logic [N*DATA_W-1:0] ld_data,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                arr_reset,
    output logic                arr_through,
    output logic [N*DATA_W-1:0] top_in,
    output logic [N*DATA_W-1:0] left_in,
    input  logic [N*DATA_W-1:0] down_out,
    output logic                res_valid,
    input  logic                res_ready,
`ifdef ARRAY_SEQ_PERF_EN
    output logic [31:0]         perf_cycles,
`endif
    output logic [N*DATA_W-1:0] res_data
);
    localparam int CNT_W = $clog2(3 * N);
    localparam logic [CNT_W-1:0] LAST_F   = CNT_W'(3 * N - 2);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N - 1);

    seq_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    f_nxt;
    logic                feed_nxt;
    logic [N-1:0]        lane_on;
    logic [LANE_W-1:0]   cnt_lane;
    logic [N*LANE_W-1:0] feed_row, feed_col, res_row, res_col;
    logic [N*DATA_W-1:0] top_rd, left_rd, top_nxt, left_nxt;
    logic                ld_fire, top_we, left_we, res_we;

    assign ld_fire  = ld_valid && ld_ready;
    assign top_we   = ld_fire && !ld_sel;
    assign left_we  = ld_fire && ld_sel;
    assign res_we   = (state == DRAIN);
    assign cnt_lane = cnt[LANE_W-1:0];

    // Feed addresses are computed for the coming cycle so top_in/left_in can be registered.
    always_comb begin
        feed_nxt = 1'b0;
        f_nxt    = '0;
        lane_on  = '0;
        feed_row = '0;
        feed_col = '0;
        res_row  = '0;
        res_col  = '0;
        if (state == CLEAR) begin
            feed_nxt = 1'b1;
        end else if (state == FEED && cnt != LAST_F) begin
            feed_nxt = 1'b1;
            f_nxt    = cnt + 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            lane_on[i] = feed_nxt && (int'(f_nxt) >= i) && (int'(f_nxt) < i + N);
            feed_row[i*LANE_W +: LANE_W] = LANE_W'(i);
            feed_col[i*LANE_W +: LANE_W] = LANE_W'(f_nxt - CNT_W'(i));
            res_row[i*LANE_W +: LANE_W]  = cnt_lane;
            res_col[i*LANE_W +: LANE_W]  = LANE_W'(i);
        end
    end

    always_comb begin
        top_nxt  = '0;
        left_nxt = '0;
        for (int i = 0; i < N; i++) begin
            if (lane_on[i]) begin
                top_nxt[i*DATA_W +: DATA_W]  = top_rd[i*DATA_W +: DATA_W];
                left_nxt[i*DATA_W +: DATA_W] = left_rd[i*DATA_W +: DATA_W];
            end
        end
    end

    array_tile_buf #(.N(N), .DATA_W(DATA_W), .LANE_W(LANE_W)) u_top_buf (
        .clk(clk), .reset(reset), .we(top_we), .wr_row(ld_lane), .wr_data(ld_data),
        .rd_row(feed_row), .rd_col(feed_col), .rd_data(top_rd)
    );

    array_tile_buf #(.N(N), .DATA_W(DATA_W), .LANE_W(LANE_W)) u_left_buf (
        .clk(clk), .reset(reset), .we(left_we), .wr_row(ld_lane), .wr_data(ld_data),
        .rd_row(feed_row), .rd_col(feed_col), .rd_data(left_rd)
    );

    array_tile_buf #(.N(N), .DATA_W(DATA_W), .LANE_W(LANE_W)) u_res_buf (
        .clk(clk), .reset(reset), .we(res_we), .wr_row(cnt_lane), .wr_data(down_out),
        .rd_row(res_row), .rd_col(res_col), .rd_data(res_data)
    );

    // One counter serves as feed step, drain row and output row depending on state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            res_valid   <= 1'b0;
            arr_through <= 1'b0;
            arr_reset   <= 1'b1;
            ld_ready    <= 1'b1;
            top_in      <= '0;
            left_in     <= '0;
        end else begin
            done    <= 1'b0;
            top_in  <= top_nxt;
            left_in <= left_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        ld_ready <= 1'b0;
                    end
                end
                CLEAR: begin
                    state     <= FEED;
                    cnt       <= '0;
                    arr_reset <= 1'b0;
                end
                FEED: begin
                    if (cnt == LAST_F) begin
                        state       <= DRAIN;
                        cnt         <= '0;
                        arr_through <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == LAST_ROW) begin
                        state       <= OUT;
                        cnt         <= '0;
                        arr_through <= 1'b0;
                        res_valid   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        if (cnt == LAST_ROW) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            res_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            arr_reset <= 1'b1;
                            ld_ready  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARRAY_SEQ_PERF_EN
    logic [31:0] perf_cnt;

    // The done cycle closes the run, so it is counted before the value freezes.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cnt <= '0;
        end else if (state == IDLE && start) begin
            perf_cnt <= '0;
        end else if (state != IDLE || done) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_cycles = perf_cnt;
`endif
endmodule

// File: tb/tb_array_seq.sv
// Self-checking bench for array_seq with a behavioural systolic array and a result scoreboard.
module tb_array_seq;
    import array_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           ld_valid = 1'b0;
    logic           ld_ready;
    logic           ld_sel = 1'b0;
    logic [1:0]     ld_lane = '0;
    logic [N*W-1:0] ld_data = '0;
    logic           start = 1'b0;
    logic           busy, done, arr_reset, arr_through;
    logic [N*W-1:0] top_in, left_in, down_out, res_data;
    logic           res_valid;
    logic           res_ready = 1'b1;
`ifdef ARRAY_SEQ_PERF_EN
    logic [31:0]    perf_cycles;
`endif

    int total = 0;
    int bad = 0;
    logic [N*W-1:0] sb[$];
    logic [W-1:0]   top_m[N][N];
    logic [W-1:0]   left_m[N][N];

    always #5 clk = ~clk;

    array_seq #(.N(N), .DATA_W(W)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_lane(ld_lane), .ld_data(ld_data),
        .start(start), .busy(busy), .done(done),
        .arr_reset(arr_reset), .arr_through(arr_through),
        .top_in(top_in), .left_in(left_in), .down_out(down_out),
        .res_valid(res_valid), .res_ready(res_ready),
`ifdef ARRAY_SEQ_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .res_data(res_data)
    );

    // Output-stationary array: left values move right, top values move down, drain shifts rows out the bottom.
    logic [W-1:0] acc[N][N];
    logic [W-1:0] a_reg[N][N];
    logic [W-1:0] b_reg[N][N];
    logic [W-1:0] ain, bin;

    always @(posedge clk) begin
        if (arr_reset) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    acc[r][c]   <= '0;
                    a_reg[r][c] <= '0;
                    b_reg[r][c] <= '0;
                end
        end else if (arr_through) begin
            for (int c = 0; c < N; c++) begin
                for (int r = N - 1; r > 0; r--) acc[r][c] <= acc[r-1][c];
                acc[0][c] <= '0;
            end
        end else begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    ain = (c == 0) ? left_in[r*W +: W] : a_reg[r][c-1];
                    bin = (r == 0) ? top_in[c*W +: W] : b_reg[r-1][c];
                    acc[r][c]   <= W'(acc[r][c] + W'(ain * bin));
                    a_reg[r][c] <= ain;
                    b_reg[r][c] <= bin;
                end
        end
    end

    always_comb begin
        down_out = '0;
        for (int c = 0; c < N; c++) down_out[c*W +: W] = acc[N-1][c];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_top(input int r, input int a, input int b, input int c, input int d);
        top_m[r][0] = W'(a); top_m[r][1] = W'(b); top_m[r][2] = W'(c); top_m[r][3] = W'(d);
    endtask

    task automatic set_left(input int r, input int a, input int b, input int c, input int d);
        left_m[r][0] = W'(a); left_m[r][1] = W'(b); left_m[r][2] = W'(c); left_m[r][3] = W'(d);
    endtask

    task automatic load_all();
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < N; r++) begin
                ld_valid = 1'b1;
                ld_sel   = s[0];
                ld_lane  = 2'(r);
                for (int c = 0; c < N; c++) ld_data[c*W +: W] = (s == 1) ? left_m[r][c] : top_m[r][c];
                tick();
            end
        ld_valid = 1'b0;
    endtask

    // Result C[r][c] = sum_k left[r][k]*top[c][k]; drain emits the bottom row first.
    task automatic push_expected();
        logic [N*W-1:0] row;
        int s;
        for (int k = 0; k < N; k++) begin
            row = '0;
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int j = 0; j < N; j++) s += int'(left_m[N-1-k][j]) * int'(top_m[c][j]);
                row[c*W +: W] = W'(s);
            end
            sb.push_back(row);
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        push_expected();
        tick();
        start = 1'b0;
    endtask

    task automatic collect_row(output logic [N*W-1:0] row, output bit got);
        got = 1'b0;
        row = '0;
        for (int t = 0; t < 200; t++) begin
            if (res_valid && res_ready) begin
                row = res_data;
                got = 1'b1;
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [N*W-1:0] row, exp;
        bit got;
        reset = 1'b1;
        tick(); tick();
        total++; if (busy !== 1'b0)        begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("[TB] FAIL reset_done got=%0b want=0", done); end
        total++; if (res_valid !== 1'b0)   begin bad++; $display("[TB] FAIL reset_res_valid got=%0b want=0", res_valid); end
        total++; if (arr_through !== 1'b0) begin bad++; $display("[TB] FAIL reset_arr_through got=%0b want=0", arr_through); end
        total++; if (arr_reset !== 1'b1)   begin bad++; $display("[TB] FAIL reset_arr_reset got=%0b want=1", arr_reset); end
        total++; if (ld_ready !== 1'b1)    begin bad++; $display("[TB] FAIL reset_ld_ready got=%0b want=1", ld_ready); end
        total++; if (top_in !== '0)        begin bad++; $display("[TB] FAIL reset_top_in got=%h want=0", top_in); end
        total++; if (left_in !== '0)       begin bad++; $display("[TB] FAIL reset_left_in got=%h want=0", left_in); end
        reset = 1'b0;
        tick();
        start_run();
        for (int k = 0; k < N; k++) begin
            collect_row(row, got);
            exp = sb.pop_front();
            total++;
            if (!got || row !== exp) begin bad++; $display("[TB] FAIL reset_buf_row%0d got=%h (seen=%0b) want=%h", k, row, got, exp); end
        end
    endtask

    task automatic test_feed();
        logic [N*W-1:0] row, exp;
        bit got;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) left_m[r][c] = (r == c) ? W'(1) : W'(0);
        set_top(0, 8, 9, 19, 21);
        set_top(1, 1, 7, 12, 5);
        set_top(2, 10, 13, 31, 4);
        set_top(3, 2, 31, 10, 11);
        load_all();
        start_run();
        tick();
        total++; if (top_in[0*W +: W] !== 8'd8) begin bad++; $display("[TB] FAIL feed_top0_f0 got=%0d want=8", top_in[0*W +: W]); end
        total++; if (top_in[1*W +: W] !== 8'd0) begin bad++; $display("[TB] FAIL feed_top1_f0 got=%0d want=0", top_in[1*W +: W]); end
        tick();
        total++; if (top_in[1*W +: W] !== 8'd1) begin bad++; $display("[TB] FAIL feed_top1_f1 got=%0d want=1", top_in[1*W +: W]); end
        tick(); tick(); tick();
        total++; if (top_in[1*W +: W] !== 8'd5) begin bad++; $display("[TB] FAIL feed_top1_f4 got=%0d want=5", top_in[1*W +: W]); end
        tick();
        total++; if (top_in[1*W +: W] !== 8'd0) begin bad++; $display("[TB] FAIL feed_top1_f5 got=%0d want=0", top_in[1*W +: W]); end
        for (int k = 0; k < N; k++) begin
            collect_row(row, got);
            exp = sb.pop_front();
            total++;
            if (!got || row !== exp) begin bad++; $display("[TB] FAIL feed_row%0d got=%h (seen=%0b) want=%h", k, row, got, exp); end
        end
    endtask

    task automatic test_latency();
        logic [N*W-1:0] row, exp;
        bit got;
        int cyc;
        set_top(0, 10, 3, 5, 7);  set_left(0, 10, 3, 5, 7);
        set_top(1, 0, 11, 9, 3);  set_left(1, 0, 11, 9, 3);
        set_top(2, 20, 8, 4, 4);  set_left(2, 20, 8, 4, 4);
        set_top(3, 8, 2, 8, 5);   set_left(3, 8, 2, 8, 5);
        load_all();
        start_run();
        cyc = 1;
        while (!res_valid && cyc < 100) begin tick(); cyc++; end
        total++; if (cyc != 17) begin bad++; $display("[TB] FAIL latency got=%0d want=17", cyc); end
        for (int k = 0; k < N; k++) begin
            collect_row(row, got);
            exp = sb.pop_front();
            total++;
            if (!got || row !== exp) begin bad++; $display("[TB] FAIL latency_row%0d got=%h (seen=%0b) want=%h", k, row, got, exp); end
        end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL done_pulse got=%0b want=1", done); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL done_width got done=%0b busy=%0b want 0 0", done, busy); end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] row, exp, hold;
        bit got;
        int t;
        res_ready = 1'b0;
        start_run();
        t = 0;
        while (!res_valid && t < 100) begin tick(); t++; end
        hold = res_data;
        for (int s = 0; s < 5; s++) begin
            tick();
            total++;
            if (res_valid !== 1'b1 || res_data !== hold) begin
                bad++; $display("[TB] FAIL stall_hold%0d got valid=%0b data=%h want valid=1 data=%h", s, res_valid, res_data, hold);
            end
        end
        res_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            collect_row(row, got);
            exp = sb.pop_front();
            total++;
            if (!got || row !== exp) begin bad++; $display("[TB] FAIL stall_row%0d got=%h (seen=%0b) want=%h", k, row, got, exp); end
        end
    endtask

    task automatic test_start_ignored();
        logic [N*W-1:0] row, exp;
        bit got;
        int cyc;
        start_run();
        cyc = 1;
        while (!res_valid && cyc < 100) begin
            start = (cyc == 5);
            tick();
            cyc++;
        end
        start = 1'b0;
        total++; if (cyc != 17) begin bad++; $display("[TB] FAIL ignored_start_latency got=%0d want=17", cyc); end
        for (int k = 0; k < N; k++) begin
            collect_row(row, got);
            exp = sb.pop_front();
            total++;
            if (!got || row !== exp) begin bad++; $display("[TB] FAIL reuse_row%0d got=%h (seen=%0b) want=%h", k, row, got, exp); end
        end
        for (int s = 0; s < 5; s++) tick();
        total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL ignored_start_rerun got busy=%0b valid=%0b want 0 0", busy, res_valid); end
    endtask

`ifdef ARRAY_SEQ_PERF_EN
    task automatic test_perf();
        logic [N*W-1:0] row, exp;
        bit got;
        start_run();
        for (int k = 0; k < N; k++) begin
            collect_row(row, got);
            exp = sb.pop_front();
            total++;
            if (!got || row !== exp) begin bad++; $display("[TB] FAIL perf_row%0d got=%h (seen=%0b) want=%h", k, row, got, exp); end
        end
        tick();
        total++; if (perf_cycles !== 32'd21) begin bad++; $display("[TB] FAIL perf_cycles got=%0d want=21", perf_cycles); end
        tick(); tick();
        total++; if (perf_cycles !== 32'd21) begin bad++; $display("[TB] FAIL perf_latch got=%0d want=21", perf_cycles); end
    endtask
`endif

    task automatic test_abort();
        int pulses;
        start_run();
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        total++; if (dut.state !== IDLE) begin bad++; $display("[TB] FAIL abort_state got=%0d want=%0d", dut.state, IDLE); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL abort_flags got busy=%0b done=%0b want 0 0", busy, done); end
        total++; if (top_in !== '0) begin bad++; $display("[TB] FAIL abort_top_in got=%h want=0", top_in); end
        reset = 1'b0;
        sb.delete();
        pulses = 0;
        for (int s = 0; s < 30; s++) begin
            if (done || res_valid) pulses++;
            tick();
        end
        total++; if (pulses != 0) begin bad++; $display("[TB] FAIL abort_no_done got=%0d want=0", pulses); end
    endtask

    initial begin
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                top_m[r][c]  = '0;
                left_m[r][c] = '0;
            end
        test_reset();
        test_feed();
        test_latency();
        test_backpressure();
        test_start_ignored();
`ifdef ARRAY_SEQ_PERF_EN
        test_perf();
`endif
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end
endmodule
